// File: rtl/mips_alu_sequencer.sv
// -----------------------------------------------------------------------------
// mips_alu_sequencer
//
// Multi-cycle issue controller between the instruction source and the ALU
// datapath of the Mini-MIPS core. One instruction is accepted at a time over a
// valid/ready handshake. R-type ALU ops (ADD SUB AND OR XOR SLT SLL SRL) and
// I-type ADDI/SLTI/ANDI/ORI are decoded. The sequencer then:
//   - reads both operands from the register file,
//   - pulses alu_start for one cycle,
//   - waits for alu_done,
//   - writes the result back.
// Any other encoding produces a one-cycle err pulse and has no side effects.
//
// Sequence: IDLE -> READ -> ISSUE -> WAIT -> WB -> IDLE (5 cycles minimum).
// Illegal encodings take IDLE -> ERR -> IDLE.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instruction[31:0]        MIPS instruction word
//   rf_raddr_a/b[4:0]        register-file read addresses (rs / rt)
//   rf_rdata_a/b[31:0]       register-file read data, sampled at the end of READ
//   alu_start                one-cycle ALU start pulse
//   alu_op[3:0]              ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7
//   alu_a/alu_b[31:0]        ALU operands
//   alu_shamt[4:0]           ALU shift amount
//   alu_done, alu_result     ALU completion and result
//   rf_we, rf_waddr, rf_wdata  register-file write port (one-cycle write enable)
//   busy                     high in every state except IDLE
//   err                      one-cycle pulse on illegal instruction or timeout
//
// Optional build macro MIPS_SEQ_TIMEOUT_EN: when defined, WAIT aborts to ERR
// after TIMEOUT_CYCLES cycles without alu_done. When undefined, WAIT holds until
// alu_done and TIMEOUT_CYCLES has no effect.
// -----------------------------------------------------------------------------
module mips_alu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  state_t state_reg, state_next;

  // Instruction fields
  logic [5:0]  f_opcode;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [5:0]  f_funct;
  logic [15:0] f_imm;

  assign f_opcode = instruction[31:26];
  assign f_rs     = instruction[25:21];
  assign f_rt     = instruction[20:16];
  assign f_rd     = instruction[15:11];
  assign f_shamt  = instruction[10:6];
  assign f_funct  = instruction[5:0];
  assign f_imm    = instruction[15:0];

  // Decode of the offered instruction (used only at the accept edge)
  logic       dec_legal;
  logic       dec_itype;
  logic       dec_shift;
  logic       dec_signext;
  logic [3:0] dec_op;
  logic [4:0] dec_dest;

  always_comb begin
    dec_legal   = 1'b1;
    dec_itype   = 1'b0;
    dec_shift   = 1'b0;
    dec_signext = 1'b0;
    dec_op      = OP_ADD;
    dec_dest    = f_rd;
    if (f_opcode == 6'h00) begin
      unique case (f_funct)
        6'h20:   dec_op = OP_ADD;
        6'h22:   dec_op = OP_SUB;
        6'h24:   dec_op = OP_AND;
        6'h25:   dec_op = OP_OR;
        6'h26:   dec_op = OP_XOR;
        6'h2A:   dec_op = OP_SLT;
        6'h00: begin dec_op = OP_SLL; dec_shift = 1'b1; end
        6'h02: begin dec_op = OP_SRL; dec_shift = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_itype = 1'b1;
      dec_dest  = f_rt;
      unique case (f_opcode)
        6'h08:   begin dec_op = OP_ADD; dec_signext = 1'b1; end
        6'h0A:   begin dec_op = OP_SLT; dec_signext = 1'b1; end
        6'h0C:   dec_op = OP_AND;
        6'h0D:   dec_op = OP_OR;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Latched decode attributes, needed when operands are formed at the end of READ
  logic        itype_reg;
  logic        shift_reg;
  logic        signext_reg;
  logic [15:0] imm_reg;
  logic [4:0]  shamt_reg;
  logic [31:0] imm_ext;

  assign imm_ext = signext_reg ? {{16{imm_reg[15]}}, imm_reg} : {16'h0000, imm_reg};

  logic accept;
  assign accept = (state_reg == S_IDLE) && instr_valid;

`ifdef MIPS_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             wait_expired;

  // Counts completed WAIT cycles; alu_done in the final cycle still wins.
  assign wait_expired = (wait_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_WAIT && !alu_done && !wait_expired) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    busy        = 1'b1;
    alu_start   = 1'b0;
    rf_we       = 1'b0;
    err         = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          state_next = dec_legal ? S_READ : S_ERR;
        end
      end
      S_READ: begin
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        alu_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          state_next = S_WB;
        end
`ifdef MIPS_SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          state_next = S_ERR;
        end
`endif
      end
      S_WB: begin
        // Writes to $0 are suppressed, but the cycle is still spent.
        rf_we      = (rf_waddr != 5'd0);
        state_next = S_IDLE;
      end
      S_ERR: begin
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_raddr_a  <= '0;
      rf_raddr_b  <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_shamt   <= '0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      itype_reg   <= 1'b0;
      shift_reg   <= 1'b0;
      signext_reg <= 1'b0;
      imm_reg     <= '0;
      shamt_reg   <= '0;
    end else begin
      // Only legal instructions touch the datapath, so a rejected encoding
      // leaves every address/data output untouched.
      if (accept && dec_legal) begin
        rf_raddr_a  <= f_rs;
        rf_raddr_b  <= f_rt;
        alu_op      <= dec_op;
        rf_waddr    <= dec_dest;
        itype_reg   <= dec_itype;
        shift_reg   <= dec_shift;
        signext_reg <= dec_signext;
        imm_reg     <= f_imm;
        shamt_reg   <= f_shamt;
      end
      if (state_reg == S_READ) begin
        // Shifts operate on the rt value.
        alu_a     <= shift_reg ? rf_rdata_b : rf_rdata_a;
        alu_b     <= itype_reg ? imm_ext : rf_rdata_b;
        alu_shamt <= shift_reg ? shamt_reg : 5'd0;
      end
      if (state_reg == S_WAIT && alu_done) begin
        rf_wdata <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_sequencer.sv
module tb_mips_alu_sequencer;

  localparam int unsigned TOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction = '0;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  mips_alu_sequencer #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_shamt   (alu_shamt),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    bit          legal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    bit          we;
    logic [31:0] result;
  } exp_t;

  // Reference: what an ALU instruction means, straight from the ISA table.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [5:0]  opc = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [4:0]  rs  = ins[25:21];
    logic [4:0]  rt  = ins[20:16];
    logic [15:0] imm = ins[15:0];
    bit shift = 0;
    e.legal = 1; e.op = 0; e.shamt = 0;
    e.a = rf[rs]; e.b = rf[rt];
    if (opc == 6'h00) begin
      e.dest = ins[15:11];
      case (fn)
        6'h20: e.op = 0;
        6'h22: e.op = 1;
        6'h24: e.op = 2;
        6'h25: e.op = 3;
        6'h26: e.op = 4;
        6'h2A: e.op = 5;
        6'h00: begin e.op = 6; shift = 1; end
        6'h02: begin e.op = 7; shift = 1; end
        default: e.legal = 0;
      endcase
      if (shift) begin
        e.a = rf[rt];
        e.shamt = ins[10:6];
      end
    end else begin
      e.dest = rt;
      case (opc)
        6'h08: begin e.op = 0; e.b = {{16{imm[15]}}, imm}; end
        6'h0A: begin e.op = 5; e.b = {{16{imm[15]}}, imm}; end
        6'h0C: begin e.op = 2; e.b = {16'h0, imm}; end
        6'h0D: begin e.op = 3; e.b = {16'h0, imm}; end
        default: e.legal = 0;
      endcase
    end
    case (e.op)
      0: e.result = e.a + e.b;
      1: e.result = e.a - e.b;
      2: e.result = e.a & e.b;
      3: e.result = e.a | e.b;
      4: e.result = e.a ^ e.b;
      5: e.result = ($signed(e.a) < $signed(e.b)) ? 32'd1 : 32'd0;
      6: e.result = e.a << e.shamt;
      default: e.result = e.a >> e.shamt;
    endcase
    e.we = e.legal && (e.dest != 0);
    return e;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", {31'd0, instr_ready}, 32'd1);
  endtask

  // Offer one instruction; alu_done arrives after 'delay' idle WAIT cycles.
  task automatic run_instr(input logic [31:0] ins, input int delay, input bit spurious);
    exp_t e = model(ins);
    wait_ready();
    instr_valid = 1'b1;
    instruction = ins;
    @(negedge clk);                       // cycle 1
    instr_valid = 1'b0;
    instruction = $urandom;
    if (!e.legal) begin
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_no_start", {31'd0, alu_start}, 32'd0);
      check("err_no_we", {31'd0, rf_we}, 32'd0);
      @(negedge clk);                     // cycle 2
      check("err_ready_back", {31'd0, instr_ready}, 32'd1);
      check("err_single", {31'd0, err}, 32'd0);
      $display("TXN ins=%h illegal", ins);
      return;
    end
    check("read_busy", {31'd0, busy}, 32'd1);
    check("read_not_ready", {31'd0, instr_ready}, 32'd0);
    check("read_err", {31'd0, err}, 32'd0);
    check("raddr_a", {27'd0, rf_raddr_a}, {27'd0, ins[25:21]});
    check("raddr_b", {27'd0, rf_raddr_b}, {27'd0, ins[20:16]});
    if (spurious) begin
      alu_done = 1'b1;                    // must be ignored outside WAIT
      alu_result = $urandom;
    end
    @(negedge clk);                       // cycle 2: ISSUE
    alu_done = 1'b0;
    check("issue_start", {31'd0, alu_start}, 32'd1);
    check("alu_op", {28'd0, alu_op}, {28'd0, e.op});
    check("alu_a", alu_a, e.a);
    check("alu_b", alu_b, e.b);
    check("alu_shamt", {27'd0, alu_shamt}, {27'd0, e.shamt});
    @(negedge clk);                       // cycle 3: WAIT
    for (int i = 0; i < delay; i++) begin
      check("wait_no_start", {31'd0, alu_start}, 32'd0);
      check("wait_no_we", {31'd0, rf_we}, 32'd0);
      check("wait_a_stable", alu_a, e.a);
      @(negedge clk);
    end
    check("wait_b_stable", alu_b, e.b);
    check("wait_op_stable", {28'd0, alu_op}, {28'd0, e.op});
    alu_done = 1'b1;
    alu_result = e.result;
    @(negedge clk);                       // WB
    alu_done = 1'b0;
    alu_result = $urandom;
    check("wb_we", {31'd0, rf_we}, {31'd0, e.we});
    check("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.dest});
    check("wb_wdata", rf_wdata, e.result);
    check("wb_err", {31'd0, err}, 32'd0);
    if (rf_we === 1'b1) rf[rf_waddr] = rf_wdata;
    @(negedge clk);                       // back in IDLE
    check("idle_ready", {31'd0, instr_ready}, 32'd1);
    check("idle_we", {31'd0, rf_we}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    $display("TXN ins=%h op=%0d a=%h b=%h dest=%0d we=%0d res=%h", ins, e.op, e.a, e.b, e.dest, e.we, e.result);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_start"}, {31'd0, alu_start}, 32'd0);
    check({tag, "_we"}, {31'd0, rf_we}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_op"}, {28'd0, alu_op}, 32'd0);
    check({tag, "_a"}, alu_a, 32'd0);
    check({tag, "_b"}, alu_b, 32'd0);
    check({tag, "_shamt"}, {27'd0, alu_shamt}, 32'd0);
    check({tag, "_raddr"}, {22'd0, rf_raddr_a, rf_raddr_b}, 32'd0);
    check({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
    check({tag, "_wdata"}, rf_wdata, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};
    logic [5:0] iop [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    logic [5:0] bad [5] = '{6'h23, 6'h2B, 6'h04, 6'h02, 6'h0F};
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 9);
    if (r < 4) w = {6'h00, w[25:6], rfn[$urandom_range(0, 7)]};
    else if (r < 8) w = {iop[$urandom_range(0, 3)], w[25:0]};
    else if (r == 8) w = {bad[$urandom_range(0, 4)], w[25:0]};
    else w = {6'h00, w[25:6], 6'h21};
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_instr(32'h00221820, 0, 1'b0);   // ADD $3,$1,$2
    run_instr(32'h2024FFFF, 1, 1'b0);   // ADDI $4,$1,-1
    run_instr(32'h34248000, 0, 1'b1);   // ORI $4,$1,0x8000
    run_instr(32'h00022900, 2, 1'b0);   // SLL $5,$2,4
    run_instr(32'h00220020, 0, 1'b0);   // ADD $0,$1,$2
    run_instr(32'h8C220000, 0, 1'b0);   // LW (illegal)

    for (int t = 0; t < 60; t++) begin
      run_instr(rand_instr(), $urandom_range(0, TOUT - 1), 1'($urandom_range(0, 1)));
    end

`ifdef MIPS_SEQ_TIMEOUT_EN
    // alu_done never arrives: abort after TOUT WAIT cycles.
    wait_ready();
    instr_valid = 1'b1;
    instruction = 32'h00221820;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < TOUT; i++) begin
      check("tout_wait_err", {31'd0, err}, 32'd0);
      check("tout_wait_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("tout_err", {31'd0, err}, 32'd1);
    check("tout_no_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    check("tout_ready", {31'd0, instr_ready}, 32'd1);
    $display("TXN timeout abort");
`endif

    // Reset raised mid-WAIT, then a late alu_done must not write.
    wait_ready();
    instr_valid = 1'b1;
    instruction = 32'h00221820;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    alu_done = 1'b1;
    alu_result = 32'hDEADBEEF;
    @(negedge clk);
    alu_done = 1'b0;
    check("late_done_we", {31'd0, rf_we}, 32'd0);
    check("late_done_ready", {31'd0, instr_ready}, 32'd1);
    check("late_done_wdata", rf_wdata, 32'd0);
    $display("TXN reset mid-wait");

    run_instr(32'h00221820, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
